// File: rtl/usb_ep0_ctl_sched.sv
// EP0 control-pipe scheduler: latches SETUP, arbitrates standard/class handlers,
// forwards the IN data stage in max-packet chunks (with ZLP) and runs the status stage.
module usb_ep0_ctl_sched #(
  parameter int MAX_PKT     = 64,
  parameter int GNT_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        setup_valid_i,
  input  logic [7:0]  setup_type_i,
  input  logic [7:0]  setup_request_i,
  input  logic [15:0] setup_value_i,
  input  logic [15:0] setup_index_i,
  input  logic [15:0] setup_length_i,
  output logic [7:0]  ctl_xfer_type,
  output logic [7:0]  ctl_xfer_request,
  output logic [15:0] ctl_xfer_value,
  output logic [15:0] ctl_xfer_index,
  output logic [15:0] ctl_xfer_length,
  output logic        ctl_xfer_req_o,
  input  logic        std_gnt_i,
  input  logic        cls_gnt_i,
  input  logic        std_tvalid_i,
  input  logic        std_tlast_i,
  input  logic [7:0]  std_tdata_i,
  output logic        std_tready_o,
  input  logic        cls_tvalid_i,
  input  logic        cls_tlast_i,
  input  logic [7:0]  cls_tdata_i,
  output logic        cls_tready_o,
  output logic        ep0_tvalid_o,
  output logic        ep0_tlast_o,
  output logic [7:0]  ep0_tdata_o,
  output logic        ep0_tzero_o,
  input  logic        ep0_tready_i,
  input  logic        status_ack_i,
  output logic        ep0_stall_o,
  output logic        busy_o
);

  localparam int PKT_W = $clog2(MAX_PKT);
  localparam int CNT_W = $clog2(GNT_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ABORT, S_REQ, S_DATA, S_ZLP, S_STATUS, S_STALL
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         type_q, type_d;
  logic [7:0]         request_q, request_d;
  logic [15:0]        value_q, value_d;
  logic [15:0]        index_q, index_d;
  logic [15:0]        length_q, length_d;
  logic               sel_cls_q, sel_cls_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [15:0]        sent_q, sent_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic               req_q, req_d;
  logic               stall_q, stall_d;
  logic               busy_q, busy_d;

  logic       sel_tvalid, sel_tlast;
  logic [7:0] sel_tdata;
  logic       in_data, in_zlp, hs, len_done, pkt_full;

  assign sel_tvalid = sel_cls_q ? cls_tvalid_i : std_tvalid_i;
  assign sel_tlast  = sel_cls_q ? cls_tlast_i  : std_tlast_i;
  assign sel_tdata  = sel_cls_q ? cls_tdata_i  : std_tdata_i;

  assign in_data  = (state_q == S_DATA);
  assign in_zlp   = (state_q == S_ZLP);
  assign hs       = in_data & sel_tvalid & ep0_tready_i;
  // 17-bit compare so wLength=65535 never aliases
  assign len_done = (({1'b0, sent_q} + 17'd1) == {1'b0, length_q});
  assign pkt_full = (pkt_q == PKT_W'(MAX_PKT - 1));

  assign ep0_tvalid_o = (in_data & sel_tvalid) | in_zlp;
  assign ep0_tdata_o  = in_data ? sel_tdata : 8'h00;
  assign ep0_tlast_o  = in_zlp | (in_data & (pkt_full | len_done | sel_tlast));
  assign ep0_tzero_o  = in_zlp;
  assign std_tready_o = in_data & ~sel_cls_q & ep0_tready_i;
  assign cls_tready_o = in_data &  sel_cls_q & ep0_tready_i;

  assign ctl_xfer_type    = type_q;
  assign ctl_xfer_request = request_q;
  assign ctl_xfer_value   = value_q;
  assign ctl_xfer_index   = index_q;
  assign ctl_xfer_length  = length_q;
  assign ctl_xfer_req_o   = req_q;
  assign ep0_stall_o      = stall_q;
  assign busy_o           = busy_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    request_d = request_q;
    value_d   = value_q;
    index_d   = index_q;
    length_d  = length_q;
    sel_cls_d = sel_cls_q;
    wait_d    = wait_q;
    sent_d    = sent_q;
    pkt_d     = pkt_q;

    if (setup_valid_i) begin
      type_d    = setup_type_i;
      request_d = setup_request_i;
      value_d   = setup_value_i;
      index_d   = setup_index_i;
      length_d  = setup_length_i;
      wait_d    = '0;
      state_d   = (state_q == S_IDLE || state_q == S_STALL) ? S_REQ : S_ABORT;
    end else begin
      case (state_q)
        S_ABORT: begin
          state_d = S_REQ;
          wait_d  = '0;
        end
        S_REQ: begin
          if (std_gnt_i || cls_gnt_i) begin
            sel_cls_d = ~std_gnt_i;
            sent_d    = '0;
            pkt_d     = '0;
            if (length_q == 16'd0)  state_d = S_STATUS;
            else if (!type_q[7])    state_d = S_STALL;
            else                    state_d = S_DATA;
          end else if (wait_q == CNT_W'(GNT_TIMEOUT - 1)) begin
            state_d = S_STALL;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (hs) begin
            sent_d = sent_q + 16'd1;
            pkt_d  = pkt_q + PKT_W'(1);
            // a short handler reply ending on a packet boundary needs a ZLP
            if (len_done)       state_d = S_STATUS;
            else if (sel_tlast) state_d = pkt_full ? S_ZLP : S_STATUS;
          end
        end
        S_ZLP: begin
          if (ep0_tready_i) state_d = S_STATUS;
        end
        S_STATUS: begin
          if (status_ack_i) begin
            state_d   = S_IDLE;
            sel_cls_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    req_d   = (state_d == S_REQ) || (state_d == S_DATA) ||
              (state_d == S_ZLP) || (state_d == S_STATUS);
    stall_d = (state_d == S_STALL);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      type_q    <= '0;
      request_q <= '0;
      value_q   <= '0;
      index_q   <= '0;
      length_q  <= '0;
      sel_cls_q <= 1'b0;
      wait_q    <= '0;
      sent_q    <= '0;
      pkt_q     <= '0;
      req_q     <= 1'b0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      request_q <= request_d;
      value_q   <= value_d;
      index_q   <= index_d;
      length_q  <= length_d;
      sel_cls_q <= sel_cls_d;
      wait_q    <= wait_d;
      sent_q    <= sent_d;
      pkt_q     <= pkt_d;
      req_q     <= req_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_usb_ep0_ctl_sched.sv
// Directed bench for usb_ep0_ctl_sched: handler stream models, an ep0 packet
// monitor, and immediate-assertion checks against hand-computed values.
module tb_usb_ep0_ctl_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        setup_valid_i = 1'b0;
  logic [7:0]  setup_type_i = '0, setup_request_i = '0;
  logic [15:0] setup_value_i = '0, setup_index_i = '0, setup_length_i = '0;
  logic [7:0]  ctl_xfer_type, ctl_xfer_request;
  logic [15:0] ctl_xfer_value, ctl_xfer_index, ctl_xfer_length;
  logic        ctl_xfer_req_o;
  logic        std_gnt_i = 1'b0, cls_gnt_i = 1'b0;
  logic        std_tvalid_i, std_tlast_i, std_tready_o;
  logic [7:0]  std_tdata_i;
  logic        cls_tvalid_i, cls_tlast_i, cls_tready_o;
  logic [7:0]  cls_tdata_i;
  logic        ep0_tvalid_o, ep0_tlast_o, ep0_tzero_o, ep0_tready_i;
  logic [7:0]  ep0_tdata_o;
  logic        status_ack_i = 1'b0;
  logic        ep0_stall_o, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  usb_ep0_ctl_sched #(.MAX_PKT(64), .GNT_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .setup_valid_i(setup_valid_i), .setup_type_i(setup_type_i),
    .setup_request_i(setup_request_i), .setup_value_i(setup_value_i),
    .setup_index_i(setup_index_i), .setup_length_i(setup_length_i),
    .ctl_xfer_type(ctl_xfer_type), .ctl_xfer_request(ctl_xfer_request),
    .ctl_xfer_value(ctl_xfer_value), .ctl_xfer_index(ctl_xfer_index),
    .ctl_xfer_length(ctl_xfer_length), .ctl_xfer_req_o(ctl_xfer_req_o),
    .std_gnt_i(std_gnt_i), .cls_gnt_i(cls_gnt_i),
    .std_tvalid_i(std_tvalid_i), .std_tlast_i(std_tlast_i),
    .std_tdata_i(std_tdata_i), .std_tready_o(std_tready_o),
    .cls_tvalid_i(cls_tvalid_i), .cls_tlast_i(cls_tlast_i),
    .cls_tdata_i(cls_tdata_i), .cls_tready_o(cls_tready_o),
    .ep0_tvalid_o(ep0_tvalid_o), .ep0_tlast_o(ep0_tlast_o),
    .ep0_tdata_o(ep0_tdata_o), .ep0_tzero_o(ep0_tzero_o),
    .ep0_tready_i(ep0_tready_i), .status_ack_i(status_ack_i),
    .ep0_stall_o(ep0_stall_o), .busy_o(busy_o)
  );

  // Handler models: stream seed+idx for len bytes, tlast on the final one
  logic       std_active = 1'b0, cls_active = 1'b0;
  int         std_len = 0, cls_len = 0;
  int         std_idx = 0, cls_idx = 0;
  logic [7:0] std_seed = '0, cls_seed = 8'hA0;

  assign std_tvalid_i = std_active && (std_idx < std_len);
  assign std_tlast_i  = std_tvalid_i && (std_idx == std_len - 1);
  assign std_tdata_i  = std_seed + 8'(std_idx);
  assign cls_tvalid_i = cls_active && (cls_idx < cls_len);
  assign cls_tlast_i  = cls_tvalid_i && (cls_idx == cls_len - 1);
  assign cls_tdata_i  = cls_seed + 8'(cls_idx);

  always @(posedge clock) begin
    if (!std_active) std_idx <= 0;
    else if (std_tvalid_i && std_tready_o) std_idx <= std_idx + 1;
    if (!cls_active) cls_idx <= 0;
    else if (cls_tvalid_i && cls_tready_o) cls_idx <= cls_idx + 1;
  end

  logic rdy_en = 1'b1, tog_en = 1'b0, tog_q = 1'b0;
  always @(posedge clock) tog_q <= ~tog_q;
  assign ep0_tready_i = rdy_en && (!tog_en || tog_q);

  // Packet monitor on the ep0 side
  logic [7:0] cap [0:255];
  int         pkt_len [0:15];
  int         cap_n = 0, pkt_n = 0, cur_len = 0, zlp_n = 0;
  logic       mon_clr = 1'b1;

  always @(posedge clock) begin
    if (mon_clr) begin
      cap_n <= 0; pkt_n <= 0; cur_len <= 0; zlp_n <= 0;
    end else if (ep0_tvalid_o && ep0_tready_i) begin
      if (ep0_tzero_o) begin
        pkt_len[pkt_n[3:0]] <= 0;
        pkt_n <= pkt_n + 1;
        zlp_n <= zlp_n + 1;
      end else begin
        cap[cap_n[7:0]] <= ep0_tdata_o;
        cap_n <= cap_n + 1;
        if (ep0_tlast_o) begin
          pkt_len[pkt_n[3:0]] <= cur_len + 1;
          pkt_n   <= pkt_n + 1;
          cur_len <= 0;
        end else begin
          cur_len <= cur_len + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] seed);
    int errs = 0;
    for (int i = 0; i < n; i++)
      if (cap[i] !== seed + 8'(i)) errs++;
    chk(tag, errs, 0);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    mon_clr = 1'b0;
  endtask

  task automatic send_setup(input logic [7:0] t, input logic [7:0] r,
                            input logic [15:0] v, input logic [15:0] ix,
                            input logic [15:0] l);
    setup_type_i = t; setup_request_i = r;
    setup_value_i = v; setup_index_i = ix; setup_length_i = l;
    setup_valid_i = 1'b1;
    @(negedge clock);
    setup_valid_i = 1'b0;
  endtask

  task automatic std_xfer(input logic [15:0] wlen, input int hlen,
                          input logic [7:0] seed, input int cycles);
    clear_mon();
    std_len = hlen; std_seed = seed;
    send_setup(8'h80, 8'h06, 16'h0100, 16'h0000, wlen);
    std_gnt_i = 1'b1; std_active = 1'b1;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic finish_status(input string tag);
    chk({tag, "_status_req"}, ctl_xfer_req_o, 1);
    chk({tag, "_status_tvalid"}, ep0_tvalid_o, 0);
    status_ack_i = 1'b1;
    @(negedge clock);
    status_ack_i = 1'b0;
    chk({tag, "_ack_req"}, ctl_xfer_req_o, 0);
    chk({tag, "_ack_busy"}, busy_o, 0);
    std_gnt_i = 1'b0; std_active = 1'b0;
    cls_gnt_i = 1'b0; cls_active = 1'b0;
  endtask

  initial begin
    logic cls_rdy_seen;
    repeat (3) @(negedge clock);
    chk("rst_req", ctl_xfer_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", ep0_stall_o, 0);
    chk("rst_tvalid", {ep0_tvalid_o, ep0_tlast_o, ep0_tzero_o}, 0);
    reset = 1'b0;

    // GET_DESCRIPTOR(device), handler replies 18 bytes, grant on 2nd REQ cycle
    clear_mon();
    std_len = 18; std_seed = 8'h10;
    send_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64);
    chk("gd_req", ctl_xfer_req_o, 1);
    chk("gd_busy", busy_o, 1);
    chk("gd_fields", {ctl_xfer_type, ctl_xfer_request, ctl_xfer_value}, 32'h8006_0100);
    chk("gd_length", ctl_xfer_length, 64);
    @(negedge clock);
    std_gnt_i = 1'b1; std_active = 1'b1;
    repeat (30) @(negedge clock);
    chk("gd_bytes", cap_n, 18);
    chk("gd_pkts", pkt_n, 1);
    chk("gd_pkt0", pkt_len[0], 18);
    chk("gd_zlp", zlp_n, 0);
    chk_bytes("gd_data", 18, 8'h10);
    finish_status("gd");

    // wLength=8 truncates the 18-byte reply
    std_xfer(16'd8, 18, 8'h40, 20);
    chk("tr_bytes", cap_n, 8);
    chk("tr_pkt0", pkt_len[0], 8);
    chk("tr_pkts", pkt_n, 1);
    chk("tr_handler_idx", std_idx, 8);
    chk_bytes("tr_data", 8, 8'h40);
    finish_status("tr");

    // 64-byte short reply to wLength=255 ends with a ZLP
    std_xfer(16'd255, 64, 8'h00, 80);
    chk("zl_bytes", cap_n, 64);
    chk("zl_pkts", pkt_n, 2);
    chk("zl_pkt0", pkt_len[0], 64);
    chk("zl_pkt1", pkt_len[1], 0);
    chk("zl_zlp", zlp_n, 1);
    finish_status("zl");

    // exact wLength=64: no ZLP
    std_xfer(16'd64, 64, 8'h80, 80);
    chk("nz_bytes", cap_n, 64);
    chk("nz_pkts", pkt_n, 1);
    chk("nz_zlp", zlp_n, 0);
    chk_bytes("nz_data", 64, 8'h80);
    finish_status("nz");

    // 130 bytes into wLength=200 with ep0_tready toggling
    tog_en = 1'b1;
    std_xfer(16'd200, 130, 8'h21, 320);
    tog_en = 1'b0;
    chk("mp_bytes", cap_n, 130);
    chk("mp_pkts", pkt_n, 3);
    chk("mp_pkt_sizes", {8'(pkt_len[0]), 8'(pkt_len[1]), 8'(pkt_len[2])}, 32'h0040_4002);
    chk("mp_zlp", zlp_n, 0);
    chk_bytes("mp_data", 130, 8'h21);
    finish_status("mp");

    // no grant: REQ holds for 4 cycles then STALL
    clear_mon();
    send_setup(8'hC0, 8'h01, 16'h0000, 16'h0000, 16'd4);
    chk("to_req0", ctl_xfer_req_o, 1);
    repeat (3) @(negedge clock);
    chk("to_req3", {ctl_xfer_req_o, ep0_stall_o}, 2'b10);
    @(negedge clock);
    chk("to_stall", {ctl_xfer_req_o, ep0_stall_o, busy_o}, 3'b011);
    status_ack_i = 1'b1;
    @(negedge clock);
    status_ack_i = 1'b0;
    chk("to_ack_ignored", {ep0_stall_o, busy_o}, 2'b11);

    // next SETUP clears stall; both grants -> standard handler wins
    std_len = 4; std_seed = 8'h55; cls_len = 4;
    std_gnt_i = 1'b1; cls_gnt_i = 1'b1; std_active = 1'b1; cls_active = 1'b1;
    send_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd4);
    chk("ar_stall_clr", {ep0_stall_o, ctl_xfer_req_o}, 2'b01);
    cls_rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cls_rdy_seen = cls_rdy_seen | cls_tready_o;
      @(negedge clock);
    end
    chk("ar_cls_tready", cls_rdy_seen, 0);
    chk("ar_cls_idx", cls_idx, 0);
    chk("ar_bytes", cap_n, 4);
    chk_bytes("ar_data", 4, 8'h55);
    finish_status("ar");

    // new SETUP after 10 data bytes -> one ABORT cycle, then REQ
    clear_mon();
    std_len = 64; std_seed = 8'h30;
    send_setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd64);
    std_gnt_i = 1'b1; std_active = 1'b1;
    for (int i = 0; i < 40 && cap_n < 10; i++) @(negedge clock);
    chk("ab_pre_bytes", cap_n, 10);
    rdy_en = 1'b0; std_gnt_i = 1'b0;
    send_setup(8'h00, 8'h05, 16'h0012, 16'h0000, 16'd0);
    rdy_en = 1'b1;
    #1;
    chk("ab_req_low", ctl_xfer_req_o, 0);
    chk("ab_busy", busy_o, 1);
    chk("ab_treadies", {std_tready_o, cls_tready_o, ep0_tvalid_o}, 0);
    chk("ab_new_fields", {ctl_xfer_type, ctl_xfer_request, ctl_xfer_value}, 32'h0005_0012);
    chk("ab_bytes", cap_n, 10);
    std_active = 1'b0; std_gnt_i = 1'b1;
    @(negedge clock);
    chk("ab_req_back", ctl_xfer_req_o, 1);
    @(negedge clock);
    chk("ab_status", {ctl_xfer_req_o, busy_o, ep0_tvalid_o}, 3'b110);

    // reset during STATUS
    reset = 1'b1;
    @(negedge clock);
    chk("rs_ctl", {ctl_xfer_req_o, busy_o, ep0_stall_o, ep0_tvalid_o, ep0_tlast_o, ep0_tzero_o}, 0);
    chk("rs_fields", {ctl_xfer_type, ctl_xfer_request, ctl_xfer_length}, 0);
    chk("rs_misc", {ctl_xfer_value, ctl_xfer_index}, 0);
    chk("rs_tready", {std_tready_o, cls_tready_o, ep0_tdata_o}, 0);
    reset = 1'b0;
    std_gnt_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_ep0_ctl_sched.md
Name: usb_ep0_ctl_sched

Overview:
Control-pipe (EP0) scheduler between the SETUP decoder and the request handlers: the standard-request handler and an optional class/vendor handler.
- Latches each SETUP and broadcasts it to both handlers with one shared request strobe, then arbitrates on their grants.
- Forwards the winner's IN byte stream to the packet layer, truncated to wLength and split into max-packet-size packets (with ZLP where required).
- Sequences the status stage, and STALLs requests that no handler grants.

Parameters:
MAX_PKT, 64, EP0 max packet size in bytes (power of two, 8..64)
GNT_TIMEOUT, 4, cycles after request assertion to wait for a grant before STALL (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
setup_valid_i  in  1  one-cycle strobe; SETUP fields valid
setup_type_i/request_i  in  8/8  bmRequestType, bRequest
setup_value_i/index_i/length_i  in  16/16/16  wValue, wIndex, wLength
ctl_xfer_type/request/value/index/length  out  8/8/16/16/16  latched SETUP fields to handlers
ctl_xfer_req_o  out  1  shared request to handlers
std_gnt_i, cls_gnt_i  in  1/1  handler grants
std_tvalid_i/tlast_i/tdata_i  in  1/1/8  standard handler stream
std_tready_o  out  1
cls_tvalid_i/tlast_i/tdata_i  in  1/1/8  class handler stream
cls_tready_o  out  1
ep0_tvalid_o/tlast_o/tdata_o  out  1/1/8  IN stream to packet layer; tlast = end of packet
ep0_tzero_o  out  1  with tvalid&tlast: zero-length packet, tdata ignored
ep0_tready_i  in  1
status_ack_i  in  1  strobe: status stage handshake completed
ep0_stall_o  out  1  STALL EP0 until next SETUP
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-transfer aborts immediately with no drain.
- States: IDLE, ABORT, REQ, DATA, ZLP, STATUS, STALL.
- setup_valid_i in any state:
  - Latch the fields on the same edge.
  - From IDLE/STALL, go to REQ (stall cleared).
  - From any other state, go to ABORT: req low for exactly 1 cycle, tready outputs low, then REQ.
- REQ:
  - ctl_xfer_req_o=1; wait counter starts at 0.
  - On the first cycle with any grant: std_gnt_i wins over cls_gnt_i; select latched until IDLE.
  - After grant: if wLength==0, go to STATUS.
  - After grant: if type[7]==0 with wLength>0 (OUT data stage, unsupported), go to STALL.
  - Otherwise go to DATA.
  - No grant after GNT_TIMEOUT cycles: go to STALL.
- DATA:
  - ep0_tvalid_o = sel_tvalid; ep0_tdata_o = sel_tdata; sel_tready = ep0_tready_i. Combinational passthrough, zero latency.
  - Non-selected tready is always 0.
  - 16-bit sent counter and packet byte counter (log2(MAX_PKT) bits) advance on each ep0 handshake.
  - ep0_tlast_o=1 on a byte that is the MAX_PKT-th of its packet, OR sent+1==wLength, OR sel_tlast.
  - sent+1==wLength: go to STATUS. Truncation: the handler's remaining bytes are left unread; it sees req drop later.
  - sel_tlast with sent+1<wLength: if (sent+1)%MAX_PKT==0 go to ZLP, else go to STATUS.
  - Counters never wrap; wLength=65535 is legal.
- ZLP: ep0_tvalid_o=ep0_tlast_o=ep0_tzero_o=1 until ep0_tready_i, then STATUS.
- STATUS:
  - ctl_xfer_req_o stays 1.
  - On status_ack_i: req drops on the next edge and state goes to IDLE.
  - status_ack_i is ignored in all other states.
- STALL: ep0_stall_o=1, req=0; held until setup_valid_i.
- ctl_xfer_req_o=1 in REQ, DATA, ZLP and STATUS only.

Test Plan:
- GET_DESCRIPTOR(device) wLength=64; std grants at cycle 2 and streams 18 bytes with tlast on the 18th -> 18 bytes out, tlast on byte 18, no ZLP, STATUS; status_ack -> req low, IDLE.
- Same request with wLength=8 -> exactly 8 bytes, tlast on byte 8; handler's byte 9 is never accepted; STATUS.
- Handler streams 64 bytes, wLength=255 -> tlast on byte 64, then one tzero packet, then STATUS. Repeat with wLength=64 -> no ZLP.
- Handler streams 130 bytes, wLength=200, ep0_tready toggling every other cycle -> packets of 64, 64 and 2 bytes; no bytes lost or duplicated.
- No grant for GNT_TIMEOUT=4 cycles -> ep0_stall_o=1, req=0. Next SETUP clears the stall; both grants that cycle -> std selected, cls_tready_o stays 0.
- New SETUP after 10 bytes of DATA -> req low for 1 cycle (ABORT), then REQ with new fields. Reset asserted during STATUS -> all outputs 0 on the next edge.
